dma_reg_responder: RTL and testbench

- Responder (target) end of the DMA register interface: accepts wr_en/rd_en/addr/wdata from the bus initiator and returns rdata.
- Holds the DMA control/status register bank that the RAL model mirrors.
- Contains a small transfer engine model that counts down a programmed length and raises done/interrupt.
- Sits between the register-bus initiator and the DMA datapath; the datapath is not part of this block.

---
 rtl/dma_reg_pkg.sv | 34 +++
 rtl/dma_xfer_counter.sv | 88 ++++++++
 rtl/dma_reg_responder.sv | 124 ++++++++++++
 tb/tb_dma_reg_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_reg_pkg.sv
// rtl/dma_reg_pkg.sv - register offsets, bit positions and engine state for the DMA register responder
package dma_reg_pkg;

   // Register byte offsets within the decoded 8-bit window
   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_SRC_ADDR = 8'h08;
   localparam logic [7:0] OFF_DST_ADDR = 8'h0C;
   localparam logic [7:0] OFF_XFER_LEN = 8'h10;
   localparam logic [7:0] OFF_REMAIN   = 8'h14;
   localparam logic [7:0] OFF_INTR     = 8'h18;
   localparam logic [7:0] OFF_ID       = 8'h1C;

   // CTRL bit positions
   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_ABORT_BIT  = 2;

   // STATUS bit positions
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_ABORTED_BIT = 2;

   // INTR_STATUS bit position
   localparam int INTR_DONE_BIT = 0;

   localparam logic [31:0] ID_VALUE_DEFAULT = 32'hD3A0_0001;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } xfer_state_t;

endpackage

// File: rtl/dma_xfer_counter.sv
// rtl/dma_xfer_counter.sv - transfer engine: IDLE/BUSY FSM, beat counter and remaining-count
module dma_xfer_counter
   import dma_reg_pkg::*;
#(
   parameter int BEAT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [15:0] i_len,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_aborted,
   output logic        o_done_pulse,
   output logic [15:0] o_remain
);

   localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

   xfer_state_t   r_state;
   logic [BW-1:0] r_beat;
   logic [15:0]   r_remain;
   logic          r_done;
   logic          r_aborted;

   logic w_beat_wrap;
   logic w_last_beat;
   logic w_zero_start;

   assign w_beat_wrap  = (r_beat == BEAT_LAST);
   // Abort takes priority over a completing beat, so no done in that cycle
   assign w_last_beat  = (r_state == ST_BUSY) && !i_abort && w_beat_wrap && (r_remain == 16'd1);
   assign w_zero_start = (r_state == ST_IDLE) && i_start && (i_len == 16'd0);

   assign o_busy       = (r_state == ST_BUSY);
   assign o_done       = r_done;
   assign o_aborted    = r_aborted;
   assign o_remain     = r_remain;
   // Lets the register bank set INTR_STATUS on the same edge that STATUS.DONE is set
   assign o_done_pulse = w_last_beat || w_zero_start;

   // Engine FSM: load on start, count beats while busy, finish or abort back to idle
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_remain  <= '0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (i_len != 16'd0) begin
                     r_remain  <= i_len;
                     r_beat    <= '0;
                     r_done    <= 1'b0;
                     r_aborted <= 1'b0;
                     r_state   <= ST_BUSY;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (i_abort) begin
                  r_state   <= ST_IDLE;
                  r_aborted <= 1'b1;
                  r_beat    <= '0;
               end else if (w_beat_wrap) begin
                  r_beat   <= '0;
                  r_remain <= r_remain - 16'd1;
                  if (r_remain == 16'd1) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dma_reg_responder.sv
// rtl/dma_reg_responder.sv - DMA register bank target: decode, registers, read mux and engine hookup
module dma_reg_responder
   import dma_reg_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                BEAT_CYCLES = 1,
   parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(ID_VALUE_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              irq,
   output logic              busy
);

   logic [DATA_W-1:0] r_src;
   logic [DATA_W-1:0] r_dst;
   logic [15:0]       r_len;
   logic              r_irq_en;
   logic              r_intr;
   logic [DATA_W-1:0] r_rdata;

   logic [7:0]        w_off;
   logic              w_hit;
   logic              w_ctrl_wr;
   logic              w_start;
   logic              w_abort;
   logic              w_intr_w1c;
   logic              w_busy;
   logic              w_done;
   logic              w_aborted;
   logic              w_done_pulse;
   logic [15:0]       w_remain;
   logic [DATA_W-1:0] w_rd_val;

   // Only the low byte is decoded; any upper address bit or a misaligned offset is unmapped
   assign w_off = addr[7:0];
   assign w_hit = ((addr >> 8) == '0) && (w_off[1:0] == 2'b00) && (w_off <= OFF_ID);

   assign w_ctrl_wr  = wr_en && w_hit && (w_off == OFF_CTRL);
   // ABORT wins over START when both are written together
   assign w_start    = w_ctrl_wr && wdata[CTRL_START_BIT] && !wdata[CTRL_ABORT_BIT];
   assign w_abort    = w_ctrl_wr && wdata[CTRL_ABORT_BIT];
   assign w_intr_w1c = wr_en && w_hit && (w_off == OFF_INTR) && wdata[INTR_DONE_BIT];

   dma_xfer_counter #(
      .BEAT_CYCLES (BEAT_CYCLES)
   ) u_xfer_counter (
      .clk          (clk),
      .i_rst        (rst_n),
      .i_start      (w_start),
      .i_abort      (w_abort),
      .i_len        (r_len),
      .o_busy       (w_busy),
      .o_done       (w_done),
      .o_aborted    (w_aborted),
      .o_done_pulse (w_done_pulse),
      .o_remain     (w_remain)
   );

   // Software-visible registers; address/length are frozen while a transfer runs
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_irq_en <= 1'b0;
         r_intr   <= 1'b0;
      end else begin
         if (wr_en && w_hit) begin
            case (w_off)
               OFF_CTRL:     r_irq_en <= wdata[CTRL_IRQ_EN_BIT];
               OFF_SRC_ADDR: if (!w_busy) r_src <= wdata;
               OFF_DST_ADDR: if (!w_busy) r_dst <= wdata;
               OFF_XFER_LEN: if (!w_busy) r_len <= wdata[15:0];
               default: ;
            endcase
         end
         // A hardware set in the same cycle as a W1C leaves the bit set
         r_intr <= (r_intr && !w_intr_w1c) || w_done_pulse;
      end
   end

   // Read mux over current register contents (pre-write values on a same-cycle write)
   always_comb begin
      w_rd_val = '0;
      if (w_hit) begin
         case (w_off)
            OFF_CTRL:     w_rd_val[CTRL_IRQ_EN_BIT] = r_irq_en;
            OFF_STATUS: begin
               w_rd_val[STAT_BUSY_BIT]    = w_busy;
               w_rd_val[STAT_DONE_BIT]    = w_done;
               w_rd_val[STAT_ABORTED_BIT] = w_aborted;
            end
            OFF_SRC_ADDR: w_rd_val = r_src;
            OFF_DST_ADDR: w_rd_val = r_dst;
            OFF_XFER_LEN: w_rd_val = {{(DATA_W-16){1'b0}}, r_len};
            OFF_REMAIN:   w_rd_val = {{(DATA_W-16){1'b0}}, w_remain};
            OFF_INTR:     w_rd_val[INTR_DONE_BIT] = r_intr;
            OFF_ID:       w_rd_val = ID_VALUE;
            default:      w_rd_val = '0;
         endcase
      end
   end

   // Read data register: captured on a read strobe, held otherwise
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_rdata <= '0;
      end else if (rd_en) begin
         r_rdata <= w_rd_val;
      end
   end

   assign rdata = r_rdata;
   assign irq   = r_intr && r_irq_en;
   assign busy  = w_busy;

endmodule

// File: tb/tb_dma_reg_responder.sv
// tb/tb_dma_reg_responder.sv - self-checking bench for dma_reg_responder with BEAT_CYCLES of 2 and 1
module tb_dma_reg_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en [2];
   logic        rd_en [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        irq   [2];
   logic        busy  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dma_reg_responder #(
      .DATA_W(32), .ADDR_W(32), .BEAT_CYCLES(2), .ID_VALUE(32'hD3A0_0001)
   ) u_dut_bc2 (
      .clk(clk), .rst_n(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .irq(irq[0]), .busy(busy[0])
   );

   dma_reg_responder #(
      .DATA_W(32), .ADDR_W(32), .BEAT_CYCLES(1), .ID_VALUE(32'hD3A0_0001)
   ) u_dut_bc1 (
      .clk(clk), .rst_n(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .irq(irq[1]), .busy(busy[1])
   );

   // Reference model: the transfer is tracked as a total cycle budget (len * beat cycles)
   logic [31:0] m_src [2];
   logic [31:0] m_dst [2];
   logic [31:0] m_rdata [2];
   logic [15:0] m_len [2];
   logic [15:0] m_hold [2];
   logic        m_irq_en [2];
   logic        m_done [2];
   logic        m_aborted [2];
   logic        m_busy [2];
   logic        m_intr [2];
   int          m_cyc [2];

   function automatic int beats(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic logic [15:0] m_remain(input int d);
      if (m_busy[d]) return 16'((m_cyc[d] + beats(d) - 1) / beats(d));
      return m_hold[d];
   endfunction

   function automatic logic [31:0] read_val(input int d, input logic [31:0] a);
      if ((a >> 8) != 0 || a[1:0] != 2'b00) return 32'd0;
      case (a[7:0])
         8'h00:   return {29'd0, 1'b0, m_irq_en[d], 1'b0};
         8'h04:   return {29'd0, m_aborted[d], m_done[d], m_busy[d]};
         8'h08:   return m_src[d];
         8'h0C:   return m_dst[d];
         8'h10:   return {16'd0, m_len[d]};
         8'h14:   return {16'd0, m_remain(d)};
         8'h18:   return {31'd0, m_intr[d]};
         8'h1C:   return 32'hD3A0_0001;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset(input int d);
      m_src[d] = 0; m_dst[d] = 0; m_rdata[d] = 0; m_len[d] = 0; m_hold[d] = 0;
      m_irq_en[d] = 0; m_done[d] = 0; m_aborted[d] = 0; m_busy[d] = 0; m_intr[d] = 0;
      m_cyc[d] = 0;
   endtask

   task automatic model_edge(input int d, input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] rv;
      logic        hit, ctrl, start, abort, w1c, was_busy, done_set;
      logic [15:0] len_pre;
      rv       = read_val(d, a);
      hit      = ((a >> 8) == 0) && (a[1:0] == 2'b00) && (a[7:0] <= 8'h1C);
      was_busy = m_busy[d];
      len_pre  = m_len[d];
      ctrl     = wr && hit && (a[7:0] == 8'h00);
      start    = ctrl && wd[0] && !wd[2];
      abort    = ctrl && wd[2];
      w1c      = wr && hit && (a[7:0] == 8'h18) && wd[0];
      done_set = 1'b0;
      if (ctrl) m_irq_en[d] = wd[1];
      if (wr && hit && !was_busy) begin
         if (a[7:0] == 8'h08) m_src[d] = wd;
         if (a[7:0] == 8'h0C) m_dst[d] = wd;
         if (a[7:0] == 8'h10) m_len[d] = wd[15:0];
      end
      if (was_busy) begin
         if (abort) begin
            m_hold[d]    = m_remain(d);
            m_busy[d]    = 1'b0;
            m_aborted[d] = 1'b1;
         end else begin
            m_cyc[d] = m_cyc[d] - 1;
            if (m_cyc[d] == 0) begin
               m_busy[d] = 1'b0;
               m_hold[d] = 16'd0;
               m_done[d] = 1'b1;
               done_set  = 1'b1;
            end
         end
      end else if (start) begin
         if (len_pre != 0) begin
            m_busy[d]    = 1'b1;
            m_cyc[d]     = int'(len_pre) * beats(d);
            m_done[d]    = 1'b0;
            m_aborted[d] = 1'b0;
         end else begin
            m_done[d] = 1'b1;
            done_set  = 1'b1;
         end
      end
      m_intr[d] = (m_intr[d] && !w1c) || done_set;
      if (rd) m_rdata[d] = rv;
   endtask

   task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   // One clock: drive DUT d, idle the other, advance both model copies, compare outputs
   task automatic tick(input int d, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < 2; i++) begin
         wr_en[i] = 1'b0; rd_en[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
      end
      wr_en[d] = wr; rd_en[d] = rd; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) model_reset(i);
         else if (i == d) model_edge(i, wr, rd, a, wd);
         else model_edge(i, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
         check("irq", i, 32'(irq[i]), 32'(m_intr[i] && m_irq_en[i]));
         check("rdata", i, rdata[i], m_rdata[i]);
      end
   endtask

   task automatic idle(input int d, input int n);
      for (int k = 0; k < n; k++) tick(d, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      int          n;
      int          d;
      logic [31:0] a;
      logic [31:0] wd;
      logic        wr;
      logic        rd;

      for (int i = 0; i < 2; i++) model_reset(i);
      rst = 1'b1;
      idle(0, 2);
      rst = 1'b0;

      // Reset readback of the whole map on both instances
      for (int i = 0; i < 2; i++)
         for (int off = 0; off <= 28; off += 4) tick(i, 1'b0, 1'b1, 32'(off), 32'd0);
      check("id_const", 1, rdata[1], 32'hD3A0_0001);

      // Plain RW registers and LEN masking
      tick(0, 1'b1, 1'b0, 32'h08, 32'h1000_0000);
      tick(0, 1'b1, 1'b0, 32'h0C, 32'h2000_0000);
      tick(0, 1'b1, 1'b0, 32'h10, 32'h0000_1234);
      tick(0, 1'b0, 1'b1, 32'h08, 32'd0); check("src_rb", 0, rdata[0], 32'h1000_0000);
      tick(0, 1'b0, 1'b1, 32'h0C, 32'd0); check("dst_rb", 0, rdata[0], 32'h2000_0000);
      tick(0, 1'b0, 1'b1, 32'h10, 32'd0); check("len_rb", 0, rdata[0], 32'h0000_1234);
      tick(0, 1'b1, 1'b0, 32'h10, 32'hFFFF_0005);
      tick(0, 1'b0, 1'b1, 32'h10, 32'd0); check("len_mask", 0, rdata[0], 32'h0000_0005);
      tick(0, 1'b0, 1'b1, 32'h20, 32'd0); check("unmapped_20", 0, rdata[0], 32'd0);
      tick(0, 1'b0, 1'b1, 32'h08, 32'd0);
      tick(0, 1'b0, 1'b1, 32'h02, 32'd0); check("unmapped_02", 0, rdata[0], 32'd0);
      tick(0, 1'b0, 1'b1, 32'h108, 32'd0); check("unmapped_hi", 0, rdata[0], 32'd0);

      // Two-beat transfer of length 3 with interrupt enabled
      tick(0, 1'b1, 1'b0, 32'h10, 32'd3);
      tick(0, 1'b1, 1'b0, 32'h00, 32'h2);
      tick(0, 1'b1, 1'b0, 32'h00, 32'h3);
      n = int'(busy[0]);
      for (int k = 0; k < 10; k++) begin
         tick(0, 1'b0, 1'b1, 32'h14, 32'd0);
         n += int'(busy[0]);
      end
      check("busy_cycles", 0, 32'(n), 32'd6);
      tick(0, 1'b0, 1'b1, 32'h04, 32'd0); check("status_done", 0, rdata[0], 32'h2);
      tick(0, 1'b0, 1'b1, 32'h18, 32'd0); check("intr_set", 0, rdata[0], 32'h1);
      check("irq_set", 0, 32'(irq[0]), 32'd1);
      tick(0, 1'b1, 1'b0, 32'h18, 32'h1); check("irq_clr", 0, 32'(irq[0]), 32'd0);

      // Abort on the single-beat instance, with a LEN write ignored while busy
      tick(1, 1'b1, 1'b0, 32'h10, 32'd10);
      tick(1, 1'b1, 1'b0, 32'h00, 32'h3);
      tick(1, 1'b1, 1'b0, 32'h10, 32'h55);
      idle(1, 3);
      tick(1, 1'b1, 1'b0, 32'h00, 32'h6);
      check("abort_busy", 1, 32'(busy[1]), 32'd0);
      tick(1, 1'b0, 1'b1, 32'h14, 32'd0); check("abort_remain", 1, rdata[1], 32'd6);
      tick(1, 1'b0, 1'b1, 32'h04, 32'd0); check("abort_status", 1, rdata[1], 32'h4);
      tick(1, 1'b0, 1'b1, 32'h10, 32'd0); check("len_frozen", 1, rdata[1], 32'd10);
      check("abort_irq", 1, 32'(irq[1]), 32'd0);

      // Same-cycle write and read of SRC
      tick(1, 1'b1, 1'b0, 32'h08, 32'hA);
      tick(1, 1'b1, 1'b1, 32'h08, 32'hB); check("rw_old", 1, rdata[1], 32'hA);
      tick(1, 1'b0, 1'b1, 32'h08, 32'd0); check("rw_new", 1, rdata[1], 32'hB);

      // Reset in the middle of a transfer
      tick(1, 1'b1, 1'b0, 32'h10, 32'd8);
      tick(1, 1'b1, 1'b0, 32'h00, 32'h3);
      idle(1, 2);
      tick(1, 1'b0, 1'b1, 32'h14, 32'd0); check("mid_remain", 1, rdata[1], 32'd6);
      rst = 1'b1;
      idle(1, 1);
      rst = 1'b0;
      check("rst_busy", 1, 32'(busy[1]), 32'd0);
      check("rst_irq", 1, 32'(irq[1]), 32'd0);
      for (int off = 0; off <= 28; off += 4) tick(1, 1'b0, 1'b1, 32'(off), 32'd0);
      tick(1, 1'b0, 1'b1, 32'h14, 32'd0); check("rst_remain", 1, rdata[1], 32'd0);

      // Zero-length start completes without going busy
      tick(1, 1'b1, 1'b0, 32'h00, 32'h1);
      check("len0_busy", 1, 32'(busy[1]), 32'd0);
      tick(1, 1'b0, 1'b1, 32'h04, 32'd0); check("len0_status", 1, rdata[1], 32'h2);
      tick(1, 1'b0, 1'b1, 32'h18, 32'd0); check("len0_intr", 1, rdata[1], 32'h1);

      // Length-1 transfer after reset
      tick(1, 1'b1, 1'b0, 32'h18, 32'h1);
      tick(1, 1'b1, 1'b0, 32'h10, 32'd1);
      tick(1, 1'b1, 1'b0, 32'h00, 32'h1);
      check("len1_busy", 1, 32'(busy[1]), 32'd1);
      idle(1, 1);
      check("len1_idle", 1, 32'(busy[1]), 32'd0);
      tick(1, 1'b0, 1'b1, 32'h04, 32'd0); check("len1_status", 1, rdata[1], 32'h2);

      // Randomized traffic against the model
      for (int k = 0; k < 800; k++) begin
         d  = int'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 9)) * 32'd4;
         if ($urandom_range(0, 15) == 0) a = a | 32'h1;
         if ($urandom_range(0, 15) == 1) a = a | 32'h100;
         wd = $urandom;
         if (a[7:0] == 8'h10) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
         if (a[7:0] == 8'h00) begin
            wd = 32'($urandom_range(0, 7));
            if (wd[2] && $urandom_range(0, 3) != 0) wd[2] = 1'b0;
         end
         wr = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 9) < 5);
         tick(d, wr, rd, a, wd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
